// File: rtl/coherence_request_arbiter.sv
// rtl/coherence_request_arbiter.sv - round-robin arbiter serialising three processor request streams onto one directory port
module coherence_request_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validP0,
  input  logic              validP1,
  input  logic              validP2,
  input  logic              operationP0,
  input  logic              operationP1,
  input  logic              operationP2,
  input  logic [ADDR_W-1:0] addressP0,
  input  logic [ADDR_W-1:0] addressP1,
  input  logic [ADDR_W-1:0] addressP2,
  input  logic [DATA_W-1:0] dataP0,
  input  logic [DATA_W-1:0] dataP1,
  input  logic [DATA_W-1:0] dataP2,
  output logic              fullP0,
  output logic              fullP1,
  output logic              fullP2,
  output logic              overflowP0,
  output logic              overflowP1,
  output logic              overflowP2,
  output logic              reqValid,
  output logic [1:0]        reqProc,
  output logic              reqOperation,
  output logic [ADDR_W-1:0] reqAddress,
  output logic [DATA_W-1:0] reqData,
  input  logic              reqAck,
  input  logic              dirDone
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         lastGrant;
  logic [1:0]         pickIdx;
  logic [1:0]         ord0, ord1, ord2;
  logic [2:0]         validIn;
  logic [2:0]         notEmpty;
  logic [2:0]         fullVec;
  logic [2:0]         popVec;
  logic [2:0]         pushOk;
  logic [2:0]         overflowVec;
  logic [ENTRY_W-1:0] entryIn [3];
  logic [ENTRY_W-1:0] fifoMem [3][DEPTH];
  logic [PTR_W-1:0]   wrPtr [3];
  logic [PTR_W-1:0]   rdPtr [3];
  logic [CNT_W-1:0]   count [3];
  logic [ENTRY_W-1:0] headEntry;

  assign validIn    = {validP2, validP1, validP0};
  assign entryIn[0] = {operationP0, addressP0, dataP0};
  assign entryIn[1] = {operationP1, addressP1, dataP1};
  assign entryIn[2] = {operationP2, addressP2, dataP2};

  assign fullP0     = fullVec[0];
  assign fullP1     = fullVec[1];
  assign fullP2     = fullVec[2];
  assign overflowP0 = overflowVec[0];
  assign overflowP1 = overflowVec[1];
  assign overflowP2 = overflowVec[2];

  assign headEntry = fifoMem[pickIdx][rdPtr[pickIdx]];

  // Per-FIFO status; a full FIFO still takes a push when the granted entry leaves it this cycle.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      notEmpty[n] = (count[n] != '0);
      fullVec[n]  = (count[n] == FULL_CNT);
      popVec[n]   = (state == ISSUE) && reqAck && (reqProc == 2'(n));
      pushOk[n]   = validIn[n] && (!fullVec[n] || popVec[n]);
    end
  end

  // Round-robin pick: search starts at the processor after the last one granted.
  always_comb begin
    case (lastGrant)
      2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    pickIdx = ord2;
    if (notEmpty[ord1]) pickIdx = ord1;
    if (notEmpty[ord0]) pickIdx = ord0;
  end

  // Entry storage; left unreset because pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 3; n++) begin
        if (pushOk[n]) fifoMem[n][wrPtr[n]] <= entryIn[n];
      end
    end
  end

  // Pointers, occupancy and sticky drop flags; reset flushes every FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 3; n++) begin
        wrPtr[n]       <= '0;
        rdPtr[n]       <= '0;
        count[n]       <= '0;
        overflowVec[n] <= 1'b0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (pushOk[n]) wrPtr[n] <= wrPtr[n] + PTR_W'(1);
        if (popVec[n]) rdPtr[n] <= rdPtr[n] + PTR_W'(1);
        case ({pushOk[n], popVec[n]})
          2'b10:   count[n] <= count[n] + CNT_W'(1);
          2'b01:   count[n] <= count[n] - CNT_W'(1);
          default: count[n] <= count[n];
        endcase
        if (validIn[n] && !pushOk[n]) overflowVec[n] <= 1'b1;
      end
    end
  end

  // Issue FSM: one transaction outstanding, payload registers hold their last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lastGrant    <= 2'd2;
      reqValid     <= 1'b0;
      reqProc      <= 2'd0;
      reqOperation <= 1'b0;
      reqAddress   <= '0;
      reqData      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|notEmpty) begin
            {reqOperation, reqAddress, reqData} <= headEntry;
            reqProc   <= pickIdx;
            lastGrant <= pickIdx;
            reqValid  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (reqAck) begin
            reqValid <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (dirDone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
